pslip_grant_arb: RTL and testbench

Grant-side arbiter for one pSLIP output port. It takes N prioritised requests, finds the highest non-zero priority and breaks ties with a round-robin pointer. It issues a registered one-hot grant and holds it until the input side accepts it. The pointer advances only on an accepted grant, following the iSLIP rule. It sits between the per-input request/priority vectors and the accept stage of the crossbar scheduler.

---
 rtl/pslip_grant_arb_pkg.sv | 27 ++
 rtl/pslip_grant_arb_if.sv | 29 ++
 rtl/pslip_grant_arb_rr_max_sel.sv | 52 +++++
 rtl/pslip_grant_arb.sv | 154 +++++++++++++++
 tb/tb_pslip_grant_arb.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pslip_grant_arb_pkg.sv
// Shared definitions for the pSLIP grant arbiter: default sizes, priority and
// pointer types, FSM state encoding and a modulo-N pointer increment helper.
package pslip_pkg;

    localparam int unsigned N_DEF    = 32'd4;
    localparam int unsigned P_DEF    = 32'd16;
    localparam int unsigned PW_DEF   = $clog2(P_DEF);
    localparam int unsigned PTRW_DEF = $clog2(N_DEF);

    typedef logic [PW_DEF-1:0]   pri_t;
    typedef logic [PTRW_DEF-1:0] ptr_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Increment an index and wrap it at n, so (n-1)+1 gives 0 for any n.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        if (v + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/pslip_grant_arb_if.sv
// Request/grant bundle between the per-input request vectors, the accept
// stage and the grant arbiter. The arbiter uses the slave modport.
interface pslip_grant_arb_if #(
    parameter int unsigned N = 32'd4,
    parameter int unsigned P = 32'd16
);
    import pslip_pkg::*;

    localparam int unsigned PW   = $clog2(P);
    localparam int unsigned PTRW = $clog2(N);

    logic [PW-1:0]   req_pri [0:N-1];
    logic            accept;
    logic [N-1:0]    grant;
    logic            grant_valid;
    logic [PW-1:0]   grant_pri;
    logic [PTRW-1:0] rr_ptr;

    modport master (
        output req_pri, accept,
        input  grant, grant_valid, grant_pri, rr_ptr
    );

    modport slave (
        input  req_pri, accept,
        output grant, grant_valid, grant_pri, rr_ptr
    );

endinterface

// File: rtl/pslip_grant_arb_rr_max_sel.sv
// Combinational selector: finds the highest request priority and the first
// requester holding it, scanning upward from the round-robin pointer.
module pslip_rr_max_sel
    import pslip_pkg::*;
#(
    parameter int unsigned N    = 32'd4,
    parameter int unsigned PW   = 32'd4,
    parameter int unsigned PTRW = 32'd2
) (
    input  logic [PW-1:0]   req_pri_i [0:N-1],
    input  logic [PTRW-1:0] rr_ptr_i,
    output logic [PW-1:0]   max_o,
    output logic [PTRW-1:0] winner_o,
    output logic            any_req_o
);

    logic [PW-1:0] max_v;
    logic          found_v;
    int            idx_v;

    // Unsigned maximum, then a rotated first-match scan starting at the pointer.
    always_comb begin
        max_v    = '0;
        found_v  = 1'b0;
        idx_v    = 0;
        winner_o = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (req_pri_i[i] > max_v) begin
                max_v = req_pri_i[i];
            end else begin
                max_v = max_v;
            end
        end
        for (int k = 0; k < int'(N); k++) begin
            idx_v = int'(rr_ptr_i) + k;
            if (idx_v >= int'(N)) begin
                idx_v = idx_v - int'(N);
            end else begin
                idx_v = idx_v;
            end
            if (!found_v && (req_pri_i[idx_v] == max_v)) begin
                winner_o = PTRW'(idx_v);
                found_v  = 1'b1;
            end else begin
                found_v  = found_v;
            end
        end
        max_o     = max_v;
        any_req_o = (max_v != '0);
    end

endmodule

// File: rtl/pslip_grant_arb.sv
// Grant-side arbiter for one pSLIP output port: registered one-hot grant held
// until accepted or withdrawn; round-robin pointer advances only on accept.
// Optional feature macro PSLIP_GRANT_TIMEOUT_EN bounds an un-accepted grant
// to TIMEOUT cycles and then advances the pointer past the stalled requester.
module pslip_grant_arb
    import pslip_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned P       = P_DEF,
    parameter int unsigned TIMEOUT = 32'd8
) (
    input  logic clk,
    input  logic rst_n,
    pslip_grant_arb_if.slave bus
);

    localparam int unsigned PW   = $clog2(P);
    localparam int unsigned PTRW = $clog2(N);

    if (N < 32'd2) begin : g_chk_n
        $error("pslip_grant_arb: N must be at least 2");
    end
    if (TIMEOUT < 32'd1) begin : g_chk_timeout
        $error("pslip_grant_arb: TIMEOUT must be at least 1");
    end

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            valid_q, valid_d;
    logic [PW-1:0]   pri_q, pri_d;
    logic [PTRW-1:0] win_q, win_d;
    logic [PTRW-1:0] ptr_q, ptr_d;

    logic [PW-1:0]   sel_max_s;
    logic [PTRW-1:0] sel_win_s;
    logic            sel_any_s;
    logic [PTRW-1:0] ptr_inc_s;

`ifdef PSLIP_GRANT_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 32'd1);
    logic [TMO_W-1:0] cnt_q, cnt_d;
`endif

    pslip_rr_max_sel #(
        .N    (N),
        .PW   (PW),
        .PTRW (PTRW)
    ) u_sel (
        .req_pri_i (bus.req_pri),
        .rr_ptr_i  (ptr_q),
        .max_o     (sel_max_s),
        .winner_o  (sel_win_s),
        .any_req_o (sel_any_s)
    );

    assign ptr_inc_s = PTRW'(wrap_inc(32'(win_q), N));

    // Next-state and next-output logic for the IDLE/GRANT FSM.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        pri_d   = pri_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
`ifdef PSLIP_GRANT_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (sel_any_s) begin
                    state_d = GRANT;
                    grant_d = {{(N-1){1'b0}}, 1'b1} << sel_win_s;
                    valid_d = 1'b1;
                    pri_d   = sel_max_s;
                    win_d   = sel_win_s;
`ifdef PSLIP_GRANT_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    grant_d = '0;
                    valid_d = 1'b0;
                    pri_d   = '0;
                end
            end
            GRANT: begin
                if (bus.accept) begin
                    state_d = IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                    pri_d   = '0;
                    ptr_d   = ptr_inc_s;
                end else if (bus.req_pri[win_q] == '0) begin
                    state_d = IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                    pri_d   = '0;
                end
`ifdef PSLIP_GRANT_TIMEOUT_EN
                else if (cnt_q == TMO_W'(TIMEOUT - 32'd1)) begin
                    state_d = IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                    pri_d   = '0;
                    ptr_d   = ptr_inc_s;
                end
`endif
                else begin
                    state_d = GRANT;
`ifdef PSLIP_GRANT_TIMEOUT_EN
                    cnt_d   = cnt_q + TMO_W'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                pri_d   = '0;
            end
        endcase
    end

    // State, grant outputs and pointer registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            pri_q   <= '0;
            win_q   <= '0;
            ptr_q   <= '0;
`ifdef PSLIP_GRANT_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            pri_q   <= pri_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
`ifdef PSLIP_GRANT_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = valid_q;
    assign bus.grant_pri   = pri_q;
    assign bus.rr_ptr      = ptr_q;

endmodule

// File: tb/tb_pslip_grant_arb.sv
// Directed self-checking bench for pslip_grant_arb: expected grants are queued
// when requests are driven and checked when grant_valid rises.
module tb_pslip_grant_arb;
    import pslip_pkg::*;

    localparam int N   = 4;
    localparam int P   = 16;
    localparam int PW  = 4;
    localparam int TMO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pslip_grant_arb_if #(.N(N), .P(P)) bus ();

    pslip_grant_arb #(.N(N), .P(P), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int idx;
        int pri;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int a, input int b, input int c, input int d);
        bus.req_pri[0] = PW'(a);
        bus.req_pri[1] = PW'(b);
        bus.req_pri[2] = PW'(c);
        bus.req_pri[3] = PW'(d);
    endtask

    task automatic push(input int idx, input int pri);
        exp_t e;
        e.idx = idx;
        e.pri = pri;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for grant_valid, then compare latency, grant and priority
    // against the oldest queued expectation.
    task automatic wait_grant(input string tag, input int exp_lat);
        int   lat;
        exp_t e;
        logic [31:0] onehot;
        lat = 0;
        while (!bus.grant_valid && lat < 10) begin
            step();
            lat++;
        end
        if (!bus.grant_valid) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s_timeout: observed no grant expected grant within 10 cycles", tag);
        end else if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s_unexpected: observed grant %0h expected none", tag, bus.grant);
        end else begin
            e = exp_q.pop_front();
            onehot = 32'd1 << e.idx;
            chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
            chk({tag, "_grant"}, 32'(bus.grant), onehot);
            chk({tag, "_pri"}, 32'(bus.grant_pri), 32'(e.pri));
        end
    endtask

    task automatic accept_grant(input string tag);
        bus.accept = 1'b1;
        step();
        bus.accept = 1'b0;
        chk({tag, "_valid_drop"}, 32'(bus.grant_valid), 32'd0);
        chk({tag, "_grant_drop"}, 32'(bus.grant), 32'd0);
    endtask

    int tie_w [5] = '{0, 1, 2, 3, 0};
    int hi;

    initial begin
        bus.accept = 1'b0;
        set_req(0, 0, 0, 0);

        // Reset state
        #12;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_valid", 32'(bus.grant_valid), 32'd0);
        chk("rst_pri", 32'(bus.grant_pri), 32'd0);
        chk("rst_ptr", 32'(bus.rr_ptr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single requester, accepted in the second grant cycle
        set_req(0, 5, 0, 0);
        push(1, 5);
        wait_grant("single", 1);
        step();
        chk("single_hold", 32'(bus.grant), 32'h2);
        accept_grant("single");
        set_req(0, 0, 0, 0);
        chk("single_ptr", 32'(bus.rr_ptr), 32'd2);

        // Accept with no grant active is ignored
        bus.accept = 1'b1;
        step();
        step();
        bus.accept = 1'b0;
        chk("idle_acc_ptr", 32'(bus.rr_ptr), 32'd2);
        chk("idle_acc_valid", 32'(bus.grant_valid), 32'd0);

        // Tie rotation from pointer 0
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        chk("tie_ptr0", 32'(bus.rr_ptr), 32'd0);
        set_req(7, 7, 7, 7);
        for (int i = 0; i < 5; i++) push(tie_w[i], 7);
        for (int i = 0; i < 5; i++) begin
            wait_grant("tie", 1);
            accept_grant("tie");
            if (i == 4) set_req(0, 0, 0, 0);
            chk("tie_ptr", 32'(bus.rr_ptr), 32'((tie_w[i] + 1) % 4));
        end

        // Move pointer to 2
        set_req(0, 1, 0, 0);
        push(1, 1);
        wait_grant("prime", 1);
        accept_grant("prime");
        set_req(0, 0, 0, 0);
        chk("prime_ptr", 32'(bus.rr_ptr), 32'd2);

        // Priority dominance and no pre-emption
        set_req(3, 9, 9, 1);
        push(2, 9);
        wait_grant("dom", 1);
        bus.req_pri[3] = 4'd15;
        step();
        chk("nopreempt_grant", 32'(bus.grant), 32'h4);
        chk("nopreempt_pri", 32'(bus.grant_pri), 32'd9);
        accept_grant("dom");
        bus.req_pri[3] = 4'd1;
        chk("dom_ptr", 32'(bus.rr_ptr), 32'd3);
        push(1, 9);
        wait_grant("dom2", 1);
        accept_grant("dom2");
        set_req(0, 0, 0, 0);
        chk("dom2_ptr", 32'(bus.rr_ptr), 32'd2);

        // Withdrawal keeps pointer
        set_req(4, 0, 0, 0);
        push(0, 4);
        wait_grant("wd", 1);
        bus.req_pri[0] = 4'd0;
        step();
        chk("wd_valid", 32'(bus.grant_valid), 32'd0);
        chk("wd_grant", 32'(bus.grant), 32'd0);
        chk("wd_ptr", 32'(bus.rr_ptr), 32'd2);

        // Withdrawal coinciding with accept counts as accept
        set_req(4, 0, 0, 0);
        push(0, 4);
        wait_grant("wdacc", 1);
        bus.req_pri[0] = 4'd0;
        accept_grant("wdacc");
        chk("wdacc_ptr", 32'(bus.rr_ptr), 32'd1);

        // Reset asserted mid-grant
        set_req(6, 6, 6, 6);
        push(1, 6);
        wait_grant("mid", 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_grant", 32'(bus.grant), 32'd0);
        chk("midrst_valid", 32'(bus.grant_valid), 32'd0);
        chk("midrst_pri", 32'(bus.grant_pri), 32'd0);
        chk("midrst_ptr", 32'(bus.rr_ptr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(0, 6);
        wait_grant("postrst", 1);
        accept_grant("postrst");
        set_req(0, 0, 0, 0);
        chk("postrst_ptr", 32'(bus.rr_ptr), 32'd1);

`ifdef PSLIP_GRANT_TIMEOUT_EN
        // Un-accepted grant expires after exactly TIMEOUT cycles
        set_req(0, 3, 0, 0);
        push(1, 3);
        wait_grant("tmo", 1);
        hi = 0;
        while (bus.grant_valid && hi < 20) begin
            hi++;
            step();
        end
        chk("tmo_cycles", 32'(hi), 32'(TMO));
        chk("tmo_ptr", 32'(bus.rr_ptr), 32'd2);
        set_req(0, 0, 0, 0);

        // Accept in the final cycle wins over the timeout
        set_req(0, 3, 0, 0);
        push(1, 3);
        wait_grant("tmoacc", 1);
        step();
        step();
        step();
        chk("tmoacc_still", 32'(bus.grant_valid), 32'd1);
        accept_grant("tmoacc");
        set_req(0, 0, 0, 0);
        chk("tmoacc_ptr", 32'(bus.rr_ptr), 32'd2);
`endif

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL leftover: observed %0d queued expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
